// File: rtl/frame_counter_pkg.sv
// Shared state encodings and run-mode constants for the frame counter.
package frame_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic WRAP = 1'b0;
    localparam logic STOP = 1'b1;

endpackage

// File: rtl/frame_counter_counter_tc.sv
// Loadable up-counter with an equality terminal-count flag; instanced for samples and frames.
module counter_tc #(
    parameter int W  = 8,
    parameter int IV = 0
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iEN,
    input  logic         iCLR,
    input  logic         iLOAD,
    input  logic [W-1:0] iECV,
    output logic [W-1:0] oCNT,
    output logic         oTC
);

    localparam logic [W-1:0] IV_W = W'(IV);

    // Clear and load both return to IV and take priority over counting.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oCNT <= IV_W;
        end else if (iCLR || iLOAD) begin
            oCNT <= IV_W;
        end else if (iEN) begin
            oCNT <= oCNT + 1'b1;
        end
    end

    assign oTC = (oCNT == iECV);

endmodule

// File: rtl/frame_counter.sv
// Two-level sample/frame counter with IDLE/RUN/DONE control and per-run latched end counts.
module frame_counter
    import frame_counter_pkg::*;
#(
    parameter int WL_IN  = 8,
    parameter int WL_OUT = 8,
    parameter int IV     = 0
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCLR,
    input  logic              iSTART,
    input  logic              iEN,
    input  logic              iMODE,
    input  logic [WL_IN-1:0]  iIN_ECV,
    input  logic [WL_OUT-1:0] iOUT_ECV,
    output logic [WL_IN-1:0]  oCNT_IN,
    output logic [WL_OUT-1:0] oCNT_OUT,
    output logic              oIN_TC,
    output logic              oOUT_TC,
    output logic              oBUSY,
    output logic              oDONE
);

    stateT             state;
    logic [WL_IN-1:0]  ecvIn;
    logic [WL_OUT-1:0] ecvOut;
    logic              mode;

    logic inHit, outHit, step, wrapIn, wrapOut, finalFrame;

    // A start or clear in the same cycle discards the count step.
    assign step       = (state == RUN) && iEN && !iSTART && !iCLR;
    assign wrapIn     = step && inHit;
    assign wrapOut    = wrapIn && outHit;
    assign finalFrame = wrapOut && (mode == STOP);

    counter_tc #(.W(WL_IN), .IV(IV)) innerCnt (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEN   (step && !finalFrame),
        .iCLR  (iCLR),
        .iLOAD (iSTART || (wrapIn && !finalFrame)),
        .iECV  (ecvIn),
        .oCNT  (oCNT_IN),
        .oTC   (inHit)
    );

    counter_tc #(.W(WL_OUT), .IV(IV)) outerCnt (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEN   (wrapIn && !finalFrame),
        .iCLR  (iCLR),
        .iLOAD (iSTART || (wrapOut && !finalFrame)),
        .iECV  (ecvOut),
        .oCNT  (oCNT_OUT),
        .oTC   (outHit)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state   <= IDLE;
            ecvIn   <= '0;
            ecvOut  <= '0;
            mode    <= WRAP;
            oIN_TC  <= 1'b0;
            oOUT_TC <= 1'b0;
            oBUSY   <= 1'b0;
            oDONE   <= 1'b0;
        end else begin
            oIN_TC  <= wrapIn;
            oOUT_TC <= wrapOut;
            if (iSTART && !iCLR) begin
                ecvIn  <= iIN_ECV;
                ecvOut <= iOUT_ECV;
                mode   <= iMODE;
            end
            if (iCLR) begin
                state <= IDLE;
                oBUSY <= 1'b0;
                oDONE <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (iSTART) begin
                        state <= RUN;
                        oBUSY <= 1'b1;
                    end
                    RUN: if (finalFrame) begin
                        state <= DONE;
                        oBUSY <= 1'b0;
                        oDONE <= 1'b1;
                    end
                    DONE: if (iSTART) begin
                        state <= RUN;
                        oBUSY <= 1'b1;
                        oDONE <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        oBUSY <= 1'b0;
                        oDONE <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_counter.sv
// Scenario bench for frame_counter: IV=0 instance for control behaviour, IV=250 instance for wrap boundaries.
module tb_frame_counter;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b0;
    logic       iCLR = 1'b0;
    logic       iSTART = 1'b0;
    logic       iEN = 1'b0;
    logic       iMODE = 1'b0;
    logic [7:0] ecvIn = '0, ecvOut = '0, ecvIn2 = '0, ecvOut2 = '0;
    logic [7:0] cntIn, cntOut, cntIn2, cntOut2;
    logic       inTc, outTc, busy, done, inTc2, outTc2, busy2, done2;

    typedef struct packed {
        logic [7:0] ci;
        logic [7:0] co;
        logic       it;
        logic       ot;
        logic       bsy;
        logic       dn;
    } expT;

    expT sb[$];
    int  checks = 0;
    int  failures = 0;

    always #5 iCLK = ~iCLK;

    frame_counter #(.WL_IN(8), .WL_OUT(8), .IV(0)) dut (
        .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iSTART(iSTART), .iEN(iEN), .iMODE(iMODE),
        .iIN_ECV(ecvIn), .iOUT_ECV(ecvOut), .oCNT_IN(cntIn), .oCNT_OUT(cntOut),
        .oIN_TC(inTc), .oOUT_TC(outTc), .oBUSY(busy), .oDONE(done)
    );

    frame_counter #(.WL_IN(8), .WL_OUT(8), .IV(250)) dut2 (
        .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iSTART(iSTART), .iEN(iEN), .iMODE(iMODE),
        .iIN_ECV(ecvIn2), .iOUT_ECV(ecvOut2), .oCNT_IN(cntIn2), .oCNT_OUT(cntOut2),
        .oIN_TC(inTc2), .oOUT_TC(outTc2), .oBUSY(busy2), .oDONE(done2)
    );

    function automatic expT mk(input int ci, input int co, input logic it, input logic ot,
                               input logic b, input logic d);
        logic [7:0] c8, o8;
        c8 = ci[7:0];
        o8 = co[7:0];
        return {c8, o8, it, ot, b, d};
    endfunction

    // One clock of stimulus; outputs are then sampled 1 time unit after the edge.
    task automatic tick(input logic s, input logic e, input logic c);
        iSTART = s;
        iEN    = e;
        iCLR   = c;
        @(posedge iCLK);
        #1;
        iSTART = 1'b0;
        iCLR   = 1'b0;
    endtask

    task automatic test_reset();
        expT e, o;
        #1 iRST = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        sb.push_back(mk(250, 250, 0, 0, 0, 0));
        #2;
        e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
        if (o !== e) begin failures++; $display("FAIL reset_iv0 got %h expected %h", o, e); end
        e = sb.pop_front(); o = {cntIn2, cntOut2, inTc2, outTc2, busy2, done2}; checks++;
        if (o !== e) begin failures++; $display("FAIL reset_iv250 got %h expected %h", o, e); end
        @(negedge iCLK);
        iRST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0));
            tick(1'b0, 1'b1, 1'b0);
            e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
            if (o !== e) begin failures++; $display("FAIL idle_hold k=%0d got %h expected %h", k, o, e); end
        end
    endtask

    task automatic test_wrap();
        expT e, o;
        ecvIn = 8'd3; ecvOut = 8'd1; iMODE = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            sb.push_back(mk(k % 4, (k / 4) % 2, k > 0 && k % 4 == 0, k > 0 && k % 8 == 0, 1, 0));
            tick(k == 0, 1'b1, 1'b0);
            e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
            if (o !== e) begin failures++; $display("FAIL wrap k=%0d got %h expected %h", k, o, e); end
        end
    endtask

    task automatic test_stop();
        expT e, o;
        ecvIn = 8'd3; ecvOut = 8'd1; iMODE = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            if (k == 0 || k == 11) sb.push_back(mk(0, 0, 0, 0, 1, 0));
            else if (k < 8)        sb.push_back(mk(k % 4, k / 4, k == 4, 0, 1, 0));
            else if (k == 8)       sb.push_back(mk(3, 1, 1, 1, 0, 1));
            else                   sb.push_back(mk(3, 1, 0, 0, 0, 1));
            tick(k == 0 || k == 11, k != 11, 1'b0);
            e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
            if (o !== e) begin failures++; $display("FAIL stop k=%0d got %h expected %h", k, o, e); end
        end
        iMODE = 1'b0;
    endtask

    task automatic test_enable();
        expT e, o;
        ecvIn = 8'd1; ecvOut = 8'd3; iMODE = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 1, 0));
        sb.push_back(mk(1, 0, 0, 0, 1, 0));
        sb.push_back(mk(1, 0, 0, 0, 1, 0));
        sb.push_back(mk(0, 1, 1, 0, 1, 0));
        sb.push_back(mk(0, 1, 0, 0, 1, 0));
        for (int k = 0; k <= 4; k++) begin
            tick(k == 0, k % 2 == 1, 1'b0);
            e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
            if (o !== e) begin failures++; $display("FAIL enable k=%0d got %h expected %h", k, o, e); end
        end
    endtask

    task automatic test_latch();
        expT e, o;
        ecvIn = 8'd3; ecvOut = 8'd7; iMODE = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            sb.push_back(mk(k % 4, k / 4, k == 4, 0, 1, 0));
            tick(k == 0, 1'b1, 1'b0);
            if (k == 0) ecvIn = 8'd1;
            e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
            if (o !== e) begin failures++; $display("FAIL latch_old k=%0d got %h expected %h", k, o, e); end
        end
        for (int k = 0; k <= 4; k++) begin
            sb.push_back(mk(k % 2, k / 2, k > 0 && k % 2 == 0, 0, 1, 0));
            tick(k == 0, 1'b1, 1'b0);
            e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
            if (o !== e) begin failures++; $display("FAIL latch_new k=%0d got %h expected %h", k, o, e); end
        end
    endtask

    task automatic test_clr();
        expT e, o;
        ecvIn = 8'd3; ecvOut = 8'd3; iMODE = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k <= 6) sb.push_back(mk(k % 4, k / 4, k == 4, 0, 1, 0));
            else        sb.push_back(mk(0, 0, 0, 0, 0, 0));
            tick(k == 0 || k == 7, 1'b1, k == 7);
            e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
            if (o !== e) begin failures++; $display("FAIL clr k=%0d got %h expected %h", k, o, e); end
        end
    endtask

    task automatic test_async_reset();
        expT e, o;
        ecvIn = 8'd3; ecvOut = 8'd3; iMODE = 1'b0;
        for (int k = 0; k <= 2; k++) begin
            sb.push_back(mk(k, 0, 0, 0, 1, 0));
            tick(k == 0, 1'b1, 1'b0);
            e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
            if (o !== e) begin failures++; $display("FAIL pre_rst k=%0d got %h expected %h", k, o, e); end
        end
        #2 iRST = 1'b1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        #1;
        e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
        if (o !== e) begin failures++; $display("FAIL async_rst got %h expected %h", o, e); end
        #1 iRST = 1'b0;
        @(negedge iCLK);
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 0));
            tick(1'b0, 1'b1, 1'b0);
            e = sb.pop_front(); o = {cntIn, cntOut, inTc, outTc, busy, done}; checks++;
            if (o !== e) begin failures++; $display("FAIL post_rst k=%0d got %h expected %h", k, o, e); end
        end
    endtask

    task automatic test_iv_wrap();
        expT e, o;
        ecvIn2 = 8'd255; ecvOut2 = 8'd251; iMODE = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            sb.push_back(mk(250 + k % 6, 250 + (k / 6) % 2, k > 0 && k % 6 == 0, k == 12, 1, 0));
            tick(k == 0, 1'b1, 1'b0);
            e = sb.pop_front(); o = {cntIn2, cntOut2, inTc2, outTc2, busy2, done2}; checks++;
            if (o !== e) begin failures++; $display("FAIL iv_wrap k=%0d got %h expected %h", k, o, e); end
        end
        // End count below IV: inner runs 250..255, 0, 1, 2 before wrapping.
        ecvIn2 = 8'd2; ecvOut2 = 8'd255;
        for (int k = 0; k <= 18; k++) begin
            sb.push_back(mk((250 + k % 9) % 256, 250 + k / 9, k > 0 && k % 9 == 0, 0, 1, 0));
            tick(k == 0, 1'b1, 1'b0);
            e = sb.pop_front(); o = {cntIn2, cntOut2, inTc2, outTc2, busy2, done2}; checks++;
            if (o !== e) begin failures++; $display("FAIL ecv_lt_iv k=%0d got %h expected %h", k, o, e); end
        end
        ecvIn2 = 8'd250;
        for (int k = 0; k <= 3; k++) begin
            sb.push_back(mk(250, 250 + k, k > 0, 0, 1, 0));
            tick(k == 0, 1'b1, 1'b0);
            e = sb.pop_front(); o = {cntIn2, cntOut2, inTc2, outTc2, busy2, done2}; checks++;
            if (o !== e) begin failures++; $display("FAIL ecv_eq_iv k=%0d got %h expected %h", k, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_stop();
        test_enable();
        test_latch();
        test_clr();
        test_async_reset();
        test_iv_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
